// File: rtl/fan_speed_controller.sv
// Fan speed sequencer: OFF/LOW/MID/HIGH on button pulses, tick-driven PWM
// with soft-start ramp-up and boundary-aligned duty changes.
module fan_speed_controller #(
    parameter int unsigned PWM_PERIOD = 100,
    parameter int unsigned DUTY_LOW   = 30,
    parameter int unsigned DUTY_MID   = 60,
    parameter int unsigned DUTY_HIGH  = 90,
    parameter int unsigned RAMP_STEP  = 5
) (
    input  logic                              i_clk,
    input  logic                              i_reset,
    input  logic                              i_tick,
    input  logic                              i_btn_speed,
    input  logic                              i_btn_off,
    output logic                              o_pwm,
    output logic [1:0]                        o_state,
    output logic [$clog2(PWM_PERIOD+1)-1:0]   o_duty,
    output logic                              o_ramping
);

    localparam int unsigned DW = $clog2(PWM_PERIOD + 1);
    // Extra headroom so duty + RAMP_STEP can never wrap
    localparam int unsigned SW = DW + $clog2(RAMP_STEP + 1) + 1;

    typedef enum logic [1:0] {
        S_OFF  = 2'b00,
        S_LOW  = 2'b01,
        S_MID  = 2'b10,
        S_HIGH = 2'b11
    } state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]   duty_q, duty_d;
    logic [DW-1:0]   target_cur, target_next;
    logic [SW-1:0]   duty_sum;
    logic            pwm_q, ramp_q;

    function automatic logic [DW-1:0] target_of(input state_t s);
        case (s)
            S_LOW:   target_of = DW'(DUTY_LOW);
            S_MID:   target_of = DW'(DUTY_MID);
            S_HIGH:  target_of = DW'(DUTY_HIGH);
            default: target_of = '0;
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        if (i_btn_off) begin
            state_d = S_OFF;
        end else if (i_btn_speed) begin
            case (state_q)
                S_OFF:   state_d = S_LOW;
                S_LOW:   state_d = S_MID;
                S_MID:   state_d = S_HIGH;
                default: state_d = S_OFF;
            endcase
        end
    end

    always_comb begin
        cnt_d       = cnt_q;
        duty_d      = duty_q;
        target_cur  = target_of(state_q);
        target_next = target_of(state_d);
        duty_sum    = SW'(duty_q) + SW'(RAMP_STEP);
        if (i_tick) begin
            if (cnt_q == DW'(PWM_PERIOD - 1)) begin
                cnt_d = '0;
                if (target_cur > duty_q) begin
                    if (duty_sum > SW'(target_cur)) begin
                        duty_d = target_cur;
                    end else begin
                        duty_d = duty_sum[DW-1:0];
                    end
                end else begin
                    duty_d = target_cur;
                end
            end else begin
                cnt_d = cnt_q + DW'(1);
            end
        end
    end

    // PWM and ramp flag are computed from next-state values so they line up
    // with the counter/duty registers they describe.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= S_OFF;
            cnt_q   <= '0;
            duty_q  <= '0;
            pwm_q   <= 1'b0;
            ramp_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            duty_q  <= duty_d;
            pwm_q   <= (cnt_d < duty_d);
            ramp_q  <= (duty_d < target_next);
        end
    end

    assign o_pwm     = pwm_q;
    assign o_state   = state_q;
    assign o_duty    = duty_q;
    assign o_ramping = ramp_q;

endmodule

// File: tb/tb_fan_speed_controller.sv
// Directed bench for fan_speed_controller: cycle model feeds a scoreboard
// queue, plus directed checks on ramp sequence, PWM counts and priority.
module tb_fan_speed_controller;

    localparam int unsigned P  = 10;
    localparam int unsigned DL = 3;
    localparam int unsigned DM = 6;
    localparam int unsigned DH = 9;
    localparam int unsigned RS = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick = 1'b0;
    logic       spd = 1'b0;
    logic       off = 1'b0;
    logic       pwm;
    logic [1:0] st;
    logic [3:0] duty;
    logic       ramp;

    fan_speed_controller #(
        .PWM_PERIOD (P),
        .DUTY_LOW   (DL),
        .DUTY_MID   (DM),
        .DUTY_HIGH  (DH),
        .RAMP_STEP  (RS)
    ) dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_tick      (tick),
        .i_btn_speed (spd),
        .i_btn_off   (off),
        .o_pwm       (pwm),
        .o_state     (st),
        .o_duty      (duty),
        .o_ramping   (ramp)
    );

    always #5 clk = ~clk;

    typedef struct {
        int st;
        int duty;
        int pwm;
        int ramp;
    } exp_t;

    exp_t q[$];
    int   n_assert = 0;
    int   n_fail   = 0;
    int   m_st = 0, m_cnt = 0, m_duty = 0;
    int   pwm_hi = 0;
    int   dseq[$];
    int   last_duty = 0;

    function automatic int tgt(input int s);
        case (s)
            1: return DL;
            2: return DM;
            3: return DH;
            default: return 0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, advance the model, push expectation, compare.
    task automatic step(input logic r, input logic t, input logic s, input logic o);
        exp_t e;
        int   old_st;
        rst = r; tick = t; spd = s; off = o;
        old_st = m_st;
        if (r) begin
            m_st = 0; m_cnt = 0; m_duty = 0;
        end else begin
            if (o) m_st = 0;
            else if (s) m_st = (m_st + 1) % 4;
            if (t) begin
                if (m_cnt == P - 1) begin
                    m_cnt = 0;
                    if (tgt(old_st) > m_duty)
                        m_duty = (m_duty + RS > tgt(old_st)) ? tgt(old_st) : m_duty + RS;
                    else
                        m_duty = tgt(old_st);
                end else begin
                    m_cnt++;
                end
            end
        end
        e.st   = m_st;
        e.duty = m_duty;
        e.pwm  = (!r && m_cnt < m_duty) ? 1 : 0;
        e.ramp = (!r && m_duty < tgt(m_st)) ? 1 : 0;
        q.push_back(e);
        @(posedge clk);
        #1;
        e = q.pop_front();
        chk("state", 32'(st), 32'(e.st));
        chk("duty", 32'(duty), 32'(e.duty));
        chk("pwm", 32'(pwm), 32'(e.pwm));
        chk("ramping", 32'(ramp), 32'(e.ramp));
        if (pwm === 1'b1) pwm_hi++;
        if (32'(duty) != last_duty) begin
            last_duty = 32'(duty);
            dseq.push_back(last_duty);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        #2;
        // Reset with ticks running
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0);
            chk("rst_state", 32'(st), 0);
            chk("rst_duty", 32'(duty), 0);
            chk("rst_pwm", 32'(pwm), 0);
            chk("rst_ramp", 32'(ramp), 0);
        end
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("post_rst_duty", 32'(duty), 0);

        // Soft start into LOW
        dseq.delete();
        dseq.push_back(0);
        last_duty = 0;
        step(1'b0, 1'b1, 1'b1, 1'b0);
        chk("low_state", 32'(st), 1);
        chk("low_ramping", 32'(ramp), 1);
        idle(40);
        chk("ramp_len", 32'(dseq.size()), 3);
        if (dseq.size() == 3) begin
            chk("ramp_0", 32'(dseq[0]), 0);
            chk("ramp_1", 32'(dseq[1]), 2);
            chk("ramp_2", 32'(dseq[2]), 3);
        end
        chk("low_settled_ramp", 32'(ramp), 0);
        pwm_hi = 0;
        idle(10);
        chk("low_pwm_count", 32'(pwm_hi), 3);

        // Full sequence LOW->MID->HIGH->OFF
        step(1'b0, 1'b1, 1'b1, 1'b0);
        chk("mid_state", 32'(st), 2);
        idle(50);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        chk("high_state", 32'(st), 3);
        idle(50);
        chk("high_duty", 32'(duty), 9);
        pwm_hi = 0;
        idle(10);
        chk("high_pwm_count", 32'(pwm_hi), 9);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        chk("wrap_state", 32'(st), 0);
        idle(10);
        chk("off_duty", 32'(duty), 0);
        pwm_hi = 0;
        idle(20);
        chk("off_pwm_count", 32'(pwm_hi), 0);

        // Button priority from MID
        step(1'b0, 1'b1, 1'b1, 1'b0);
        idle(5);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        chk("prio_mid", 32'(st), 2);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        chk("prio_off", 32'(st), 0);
        idle(20);

        // Mid-period hold: OFF pressed at counter 4 while in HIGH
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b0);
        idle(60);
        for (int k = 0; k < 12 && m_cnt != 3; k++) idle(1);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        chk("hold_state", 32'(st), 0);
        chk("hold_duty", 32'(duty), 9);
        pwm_hi = 0;
        idle(10);
        chk("hold_pwm_until_boundary", 32'(pwm_hi), 4);
        chk("hold_duty_after", 32'(duty), 0);
        pwm_hi = 0;
        idle(10);
        chk("hold_pwm_off", 32'(pwm_hi), 0);

        // Tick gating: tick every 7th cycle, button between ticks
        for (int i = 0; i < 210; i++) begin
            logic prev;
            logic t;
            prev = pwm;
            t = (i % 7 == 0);
            step(1'b0, t, (i == 3), 1'b0);
            if (i == 3) chk("gated_btn_state", 32'(st), 1);
            if (!t) chk("gated_pwm_hold", 32'(pwm), 32'(prev));
        end
        chk("gated_duty", 32'(duty), 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
